// File: rtl/flex_pts_pkg.sv
// flex_pts_pkg: shared types and helpers for the flex parallel-to-serial transmitter.
//   pts_state_t : FSM state encoding (PARITY is only reachable when FLEX_PTS_PARITY_EN is defined)
//   cnt_width() : counter width for a given number of counter values, never below 1 bit
package flex_pts_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } pts_state_t;

   // Width of a counter that must hold values 0..range-1.
   function automatic int unsigned cnt_width(input int unsigned range);
      int unsigned w;
      w = unsigned'($clog2(range));
      if (w < 32'd1) begin
         w = 32'd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/flex_pts_serializer_if.sv
// flex_pts_serializer_if: word handshake and serial line bundle for flex_pts_serializer.
//   in_valid, parallel_in : producer -> transmitter word offer
//   in_ready              : transmitter can accept a word
//   serial_out            : idle-high serial line
//   busy, frame_done      : frame status
interface flex_pts_serializer_if #(
   parameter int unsigned NUM_BITS = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [NUM_BITS-1:0] parallel_in;
   logic                serial_out;
   logic                busy;
   logic                frame_done;

   modport master (
      output in_valid,
      output parallel_in,
      input  in_ready,
      input  serial_out,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  parallel_in,
      output in_ready,
      output serial_out,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/flex_bit_timer.sv
// flex_bit_timer: counts 0..BIT_CYCLES-1 while enabled and flags the terminal count.
//   clk, n_rst      : clock, async active-low reset
//   clear_i         : force the counter to 0 (takes priority over enable)
//   enable_i        : advance the counter
//   bit_strobe_c_o  : combinational one-cycle strobe on the terminal count
module flex_bit_timer
   import flex_pts_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic bit_strobe_c_o
);

   localparam int unsigned   CW   = cnt_width(BIT_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 32'd1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          term_c;

   assign term_c         = (cnt_q == TERM);
   assign bit_strobe_c_o = enable_i && !clear_i && term_c;

   // Next count: wrap to 0 at terminal count so BIT_CYCLES=1 strobes every cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = term_c ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/flex_pts_serializer.sv
// flex_pts_serializer: valid/ready word in, idle-high serial line out, each bit held
// BIT_CYCLES clocks, MSB- or LSB-first. frame_done pulses in the first idle cycle after
// a frame. Defining FLEX_PTS_PARITY_EN appends an even-parity bit after the data bits.
//   clk, n_rst : clock, async active-low reset (aborts any frame, line returns high)
//   pts_bus    : slave side of flex_pts_serializer_if
//                (in_valid/parallel_in in; in_ready/serial_out/busy/frame_done out)
module flex_pts_serializer
   import flex_pts_pkg::*;
#(
   parameter int unsigned NUM_BITS   = 8,
   parameter int unsigned SHIFT_MSB  = 1,
   parameter int unsigned BIT_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        n_rst,
   flex_pts_serializer_if.slave        pts_bus
);

   localparam int unsigned   IW       = cnt_width(NUM_BITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BITS - 32'd1);

   pts_state_t          state_q, state_d;
   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                serial_q, serial_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                accept_c;
   logic                bit_strobe_c;
`ifdef FLEX_PTS_PARITY_EN
   logic                parity_q, parity_d;
`endif

   // Bit currently at the transmit end of the register.
   function automatic logic head_of(input logic [NUM_BITS-1:0] v);
      return (SHIFT_MSB != 32'd0) ? v[NUM_BITS-1] : v[0];
   endfunction

   // Move the next bit to the head; the vacated end refills with idle-level ones.
   function automatic logic [NUM_BITS-1:0] shift_of(input logic [NUM_BITS-1:0] v);
      return (SHIFT_MSB != 32'd0) ? {v[NUM_BITS-2:0], 1'b1} : {1'b1, v[NUM_BITS-1:1]};
   endfunction

   assign accept_c = pts_bus.in_valid && ready_q;

   flex_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk            (clk),
      .n_rst          (n_rst),
      .clear_i        (accept_c),
      .enable_i       (state_q != IDLE),
      .bit_strobe_c_o (bit_strobe_c)
   );

   // Next state, datapath and output values; outputs are registered from next-state values
   // so serial_out shows the first data bit in the cycle right after acceptance.
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
`ifdef FLEX_PTS_PARITY_EN
      parity_d = parity_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               sr_d    = pts_bus.parallel_in;
               idx_d   = '0;
               state_d = SHIFT;
`ifdef FLEX_PTS_PARITY_EN
               parity_d = ^pts_bus.parallel_in;
`endif
            end
         end
         SHIFT: begin
            if (bit_strobe_c) begin
               sr_d  = shift_of(sr_q);
               idx_d = idx_q + IW'(1);
               if (idx_q == LAST_IDX) begin
`ifdef FLEX_PTS_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end
            end
         end
`ifdef FLEX_PTS_PARITY_EN
         PARITY: begin
            if (bit_strobe_c) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      serial_d = 1'b1;
      if (state_d == SHIFT) begin
         serial_d = head_of(sr_d);
      end
`ifdef FLEX_PTS_PARITY_EN
      if (state_d == PARITY) begin
         serial_d = parity_d;
      end
`endif
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         sr_q     <= '1;
         idx_q    <= '0;
         serial_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef FLEX_PTS_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         idx_q    <= idx_d;
         serial_q <= serial_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef FLEX_PTS_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign pts_bus.in_ready   = ready_q;
   assign pts_bus.serial_out = serial_q;
   assign pts_bus.busy       = busy_q;
   assign pts_bus.frame_done = done_q;

endmodule

// File: tb/tb_flex_pts_serializer.sv
// tb_flex_pts_serializer: three transmitters (MSB/BC=2, LSB/BC=2, MSB/BC=1) checked every
// cycle against a frame-level model, plus directed literal expectations.
module tb_flex_pts_serializer;

   localparam int unsigned NB = 8;
`ifdef FLEX_PTS_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif
   localparam int unsigned MSB_P [3] = '{1, 0, 1};
   localparam int unsigned BC_P  [3] = '{2, 2, 1};

   logic clk;
   logic n_rst;
   logic          valid [3];
   logic [NB-1:0] pin   [3];
   logic so [3];
   logic rd [3];
   logic bz [3];
   logic dn [3];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model state: active frame, acceptance edge and captured word per instance.
   bit            act [3] = '{0, 0, 0};
   int            k_m [3] = '{0, 0, 0};
   logic [NB-1:0] w_m [3];

   flex_pts_serializer_if #(.NUM_BITS(NB)) if0 ();
   flex_pts_serializer_if #(.NUM_BITS(NB)) if1 ();
   flex_pts_serializer_if #(.NUM_BITS(NB)) if2 ();

   assign if0.in_valid = valid[0];  assign if0.parallel_in = pin[0];
   assign if1.in_valid = valid[1];  assign if1.parallel_in = pin[1];
   assign if2.in_valid = valid[2];  assign if2.parallel_in = pin[2];
   assign so[0] = if0.serial_out;   assign rd[0] = if0.in_ready;
   assign bz[0] = if0.busy;         assign dn[0] = if0.frame_done;
   assign so[1] = if1.serial_out;   assign rd[1] = if1.in_ready;
   assign bz[1] = if1.busy;         assign dn[1] = if1.frame_done;
   assign so[2] = if2.serial_out;   assign rd[2] = if2.in_ready;
   assign bz[2] = if2.busy;         assign dn[2] = if2.frame_done;

   flex_pts_serializer #(.NUM_BITS(NB), .SHIFT_MSB(1), .BIT_CYCLES(2)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .pts_bus(if0));
   flex_pts_serializer #(.NUM_BITS(NB), .SHIFT_MSB(0), .BIT_CYCLES(2)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .pts_bus(if1));
   flex_pts_serializer #(.NUM_BITS(NB), .SHIFT_MSB(1), .BIT_CYCLES(1)) u_dut2 (
      .clk(clk), .n_rst(n_rst), .pts_bus(if2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int fl_of(input int i);
      return int'((NB + PAR) * BC_P[i]);
   endfunction

   // j-th transmitted symbol of the captured word: data bits in order, then parity.
   function automatic logic seq_bit(input int i, input int j);
      logic [NB-1:0] w;
      w = w_m[i];
      if (j < int'(NB)) begin
         return (MSB_P[i] != 0) ? w[int'(NB) - 1 - j] : w[j];
      end
      return ^w;
   endfunction

   task automatic model_out(input int i, output logic s, output logic b,
                            output logic r, output logic d);
      int t;
      s = 1'b1; b = 1'b0; r = 1'b1; d = 1'b0;
      if (act[i]) begin
         t = cyc - k_m[i] - 1;
         if (t < fl_of(i)) begin
            b = 1'b1;
            r = 1'b0;
            s = seq_bit(i, t / int'(BC_P[i]));
         end else if (t == fl_of(i)) begin
            d = 1'b1;
         end
      end
   endtask

   task automatic chk(input string nm, input logic a, input logic e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // Model: accept whenever the frame-level rules say the transmitter is free.
   always @(posedge clk) begin
      if (n_rst) begin
         for (int i = 0; i < 3; i++) begin
            if (valid[i] && (!act[i] || (cyc > k_m[i] + fl_of(i)))) begin
               act[i] = 1'b1;
               k_m[i] = cyc;
               w_m[i] = pin[i];
            end
         end
      end
      cyc++;
   end

   always @(negedge n_rst) begin
      for (int i = 0; i < 3; i++) act[i] = 1'b0;
   end

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      logic es, eb, er, ed;
      for (int i = 0; i < 3; i++) begin
         model_out(i, es, eb, er, ed);
         chk($sformatf("i%0d serial_out", i), so[i], es);
         chk($sformatf("i%0d busy", i), bz[i], eb);
         chk($sformatf("i%0d in_ready", i), rd[i], er);
         chk($sformatf("i%0d frame_done", i), dn[i], ed);
      end
   end

   // Advance to the negative edge of cycle c (bounded).
   task automatic goto(input int c);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cyc < c && n < 500);
      if (cyc != c) begin
         n_checks++;
         n_fail++;
         $display("FAIL goto: reached cycle %0d expected %0d", cyc, c);
      end
   endtask

   // Offer a word for one edge (or keep offering when hold=1); k = acceptance edge.
   task automatic start(input int i, input logic [NB-1:0] w, input bit hold, output int k);
      @(posedge clk);
      #1;
      valid[i] = 1'b1;
      pin[i]   = w;
      @(posedge clk);
      #1;
      k = cyc - 1;
      if (!hold) valid[i] = 1'b0;
   endtask

   initial begin
      int k;
      int d0;
      int b2;
      logic [15:0] pat;
      logic [7:0]  pat8;
      d0 = (PAR != 0) ? 19 : 17;
      b2 = (PAR != 0) ? 10 : 9;
      for (int i = 0; i < 3; i++) begin
         valid[i] = 1'b0;
         pin[i]   = '0;
      end
      n_rst = 1'b1;
      #1 n_rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset serial_out", so[0], 1'b1);
      chk("reset in_ready", rd[0], 1'b1);
      chk("reset busy", bz[0], 1'b0);
      chk("reset frame_done", dn[0], 1'b0);
      n_rst = 1'b1;

      // MSB first, 2 clocks per bit, word 0x0F
      start(0, 8'h0F, 1'b0, k);
      pat = 16'b0000_0000_1111_1111;
      for (int n = 1; n <= 16; n++) begin
         goto(k + n);
         chk("msb 0x0F serial_out", so[0], pat[16 - n]);
      end
      goto(k + d0);
      chk("msb frame_done", dn[0], 1'b1);
      chk("msb in_ready", rd[0], 1'b1);

      // LSB first, 2 clocks per bit, word 0x0F
      start(1, 8'h0F, 1'b0, k);
      pat = 16'b1111_1111_0000_0000;
      for (int n = 1; n <= 16; n++) begin
         goto(k + n);
         chk("lsb 0x0F serial_out", so[1], pat[16 - n]);
         chk("lsb busy", bz[1], 1'b1);
      end
      goto(k + d0);
      chk("lsb frame_done", dn[1], 1'b1);

      // 1 clock per bit, word 0x07 (parity 1 when enabled)
      start(2, 8'h07, 1'b0, k);
      pat8 = 8'b0000_0111;
      for (int n = 1; n <= 8; n++) begin
         goto(k + n);
         chk("bc1 0x07 serial_out", so[2], pat8[8 - n]);
      end
`ifdef FLEX_PTS_PARITY_EN
      goto(k + 9);
      chk("parity of 0x07", so[2], 1'b1);
      goto(k + 10);
      chk("parity frame_done", dn[2], 1'b1);
      start(2, 8'h03, 1'b0, k);
      goto(k + 9);
      chk("parity of 0x03", so[2], 1'b0);
      goto(k + 10);
`else
      goto(k + 9);
      chk("bc1 frame_done", dn[2], 1'b1);
      chk("bc1 idle serial_out", so[2], 1'b1);
`endif

      // Back-to-back with in_valid held: one idle-high guard cycle
      start(2, 8'hA5, 1'b1, k);
      pin[2] = 8'h3C;
      goto(k + b2);
      chk("b2b guard serial_out", so[2], 1'b1);
      chk("b2b guard in_ready", rd[2], 1'b1);
      chk("b2b guard frame_done", dn[2], 1'b1);
      @(posedge clk);
      #1 valid[2] = 1'b0;
      goto(k + b2 + 1);
      chk("b2b 2nd bit7", so[2], 1'b0);
      chk("b2b 2nd busy", bz[2], 1'b1);
      goto(k + b2 + 3);
      chk("b2b 2nd bit5", so[2], 1'b1);
      goto(k + 2 * b2);
      chk("b2b 2nd frame_done", dn[2], 1'b1);

      // Reset during bit 3 aborts the frame
      start(0, 8'hA5, 1'b0, k);
      goto(k + 7);
      #2 n_rst = 1'b0;
      #1;
      chk("abort serial_out", so[0], 1'b1);
      chk("abort busy", bz[0], 1'b0);
      chk("abort in_ready", rd[0], 1'b1);
      @(posedge clk);
      #1 n_rst = 1'b1;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         chk("abort no frame_done", dn[0], 1'b0);
      end
      start(0, 8'h3C, 1'b0, k);
      goto(k + 5);
      chk("post-abort bit5", so[0], 1'b1);
      goto(k + 7);
      chk("post-abort bit4", so[0], 1'b1);
      goto(k + 13);
      chk("post-abort bit1", so[0], 1'b0);
      goto(k + d0);
      chk("post-abort frame_done", dn[0], 1'b1);

      // Offer a new word while busy: ignored, current word unaffected
      start(1, 8'h5A, 1'b0, k);
      goto(k + 3);
      pin[1]   = 8'hFF;
      valid[1] = 1'b1;
      @(posedge clk);
      #1 valid[1] = 1'b0;
      goto(k + 5);
      chk("busy-ignore bit2", so[1], 1'b0);
      goto(k + 11);
      chk("busy-ignore bit5", so[1], 1'b0);
      goto(k + d0);
      chk("busy-ignore frame_done", dn[1], 1'b1);
      goto(k + d0 + 2);
      chk("busy-ignore not accepted", bz[1], 1'b0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flex_pts_serializer.md
# flex_pts_serializer

Parametrised parallel-to-serial transmitter with a valid/ready word handshake, a programmable bit period, and selectable bit order. A word is accepted in one cycle, then shifted out on a registered, idle-high serial line with each bit held for a fixed number of clocks. Completion is signalled by a one-cycle pulse. It sits between a word-producing FIFO or controller and a serial pin or link, and is the framed, self-timed generalisation of the team's flex shift-register family.

## Interface
- NUM_BITS, 8: data bits per word, ≥2.
- SHIFT_MSB, 1: 1 = MSB first, 0 = LSB first.
- BIT_CYCLES, 4: clocks each bit is held on serial_out, ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has a word on parallel_in.
- in_ready  out  1  block can accept a word; high only in IDLE.
- parallel_in  in  NUM_BITS  word to transmit; sampled only on acceptance.
- serial_out  out  1  registered serial line; 1 when idle.
- busy  out  1  frame in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse after the last bit period ends.

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE behaviour:
  - in_ready=1, serial_out=1, busy=0.
  - Acceptance occurs on in_valid && in_ready at a rising edge.
  - On acceptance: capture parallel_in into the shift register, clear the bit index and cycle counter, and enter SHIFT.
- SHIFT behaviour:
  - serial_out holds the current head bit: bit NUM_BITS-1 when SHIFT_MSB=1, bit 0 when SHIFT_MSB=0.
  - The cycle counter counts 0..BIT_CYCLES-1. At its terminal count, the register shifts toward the head and fills the vacated end with 1, and the bit index increments.
  - After bit index NUM_BITS-1 completes, go to PARITY (macro on) or IDLE (macro off).
- PARITY: serial_out = even parity (XOR of all captured data bits) for BIT_CYCLES clocks, then go to IDLE.
- frame_done pulses in the first IDLE cycle after a frame.
- Accept path:
  - in_valid is ignored while busy; the producer must hold it.
  - parallel_in changes after acceptance have no effect.
- Counter widths: $clog2 of the range, minimum 1 bit. BIT_CYCLES=1 requires no special-casing.

## Timing
- Reset values: serial_out=1, in_ready=1, busy=0, frame_done=0; state IDLE; shift register all 1s; counters 0.
- If acceptance occurs at edge k, data bit i drives serial_out during cycles k+1+i·BIT_CYCLES through k+(i+1)·BIT_CYCLES.
- Frame length is NUM_BITS·BIT_CYCLES cycles, plus BIT_CYCLES with parity.
- frame_done and in_ready are high in cycle k+1+frame length. A new word can be accepted at the edge ending that cycle.
- Back-to-back transfers with in_valid held high leave exactly one idle-high cycle between frames, which acts as the guard bit. Throughput is one word per frame length + 1 cycles.
- Reset mid-frame aborts the frame: serial_out goes to 1 immediately (asynchronously), the word is discarded, and no frame_done is generated.

## Configuration
- FLEX_PTS_PARITY_EN defined: PARITY state compiled in, and an even-parity bit is appended after the data bits.
- FLEX_PTS_PARITY_EN undefined: no PARITY state or parity logic, and SHIFT returns directly to IDLE.

## Structure
- Package flex_pts_pkg contains:
  - typedef enum pts_state_t {IDLE, SHIFT, PARITY};
  - a localparam function for the minimum-1 counter width.
- Sub-module flex_bit_timer (parameter BIT_CYCLES): a cycle counter with clear and enable inputs that outputs a single-cycle bit_strobe at terminal count. The top level owns the FSM, the shift register and the bit index.

## Test plan
- NUM_BITS=8, SHIFT_MSB=1, BIT_CYCLES=2, accept 0x0F at edge 0 -> serial_out 0,0,0,0,1,1,1,1, each bit for 2 cycles over cycles 1–16; frame_done and in_ready high in cycle 17.
- Same configuration with SHIFT_MSB=0, word 0x0F -> serial_out 1,1,1,1,0,0,0,0; busy high in cycles 1–16.
- FLEX_PTS_PARITY_EN, BIT_CYCLES=1, word 0x07 -> 8 data bits, then parity bit 1 in cycle 9; frame_done in cycle 10. Word 0x03 -> parity bit 0.
- in_valid held high with words 0xA5 then 0x3C, BIT_CYCLES=1 -> exactly one cycle of serial_out=1 between frames; second frame bits begin in cycle 10.
- Pulse n_rst low during bit 3 of a frame -> serial_out=1 and busy=0 immediately; no frame_done; next word transmits correctly.
- Change parallel_in and pulse in_valid while busy -> transmitted bits are unchanged and the second word is not accepted.
